sw_debounce: RTL and testbench

- Input-side conditioning block for the board's slide switches and push buttons; it is the counterpart of the LED output path.
- Synchronises N raw asynchronous switch lines into clk, debounces each line independently with a stable-time counter, and publishes three things per channel:
  - a clean level;
  - single-cycle rise and fall pulses;
  - a toggle flag that flips on each rise.
- Sits between the top-level switch pins and the user logic (blink enables, mode selects).

---
 rtl/sw_debounce.sv | 107 ++++++++++
 tb/tb_sw_debounce.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Switch/button input conditioning: two-flop synchroniser, per-channel stable-time
// debounce, and registered rise/fall pulses plus a rise-driven toggle flag.
module sw_debounce #(
    parameter int N = 8,
    parameter int M = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    output logic [N-1:0] sw_db,
    output logic [N-1:0] sw_rise,
    output logic [N-1:0] sw_fall,
    output logic [N-1:0] sw_toggle
);

    localparam int CW = $clog2(M);
    localparam logic [CW-1:0] CNT_LAST = CW'(M - 1);

    // Channel state is implied by the clean level and whether a count is in progress
    localparam logic [1:0] STABLE_LO = 2'b00;
    localparam logic [1:0] WAIT_HI   = 2'b01;
    localparam logic [1:0] STABLE_HI = 2'b10;
    localparam logic [1:0] WAIT_LO   = 2'b11;

    logic [N-1:0] s1_reg;
    logic [N-1:0] s2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= '0;
            s2_reg <= '0;
        end else begin
            s1_reg <= sw;
            s2_reg <= s1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          db_reg;
            logic          db_next;
            logic          rise_reg;
            logic          rise_next;
            logic          fall_reg;
            logic          fall_next;
            logic          tog_reg;
            logic          tog_next;
            logic [1:0]    state;
            logic          differs;

            assign state   = {db_reg, (cnt_reg != '0)};
            assign differs = (s2_reg[gi] != db_reg);

            always_comb begin
                cnt_next  = '0;
                db_next   = db_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;
                tog_next  = tog_reg;
                case (state)
                    STABLE_LO, STABLE_HI: begin
                        if (differs) begin
                            cnt_next = CW'(1);
                        end
                    end
                    WAIT_HI, WAIT_LO: begin
                        // Any return to the clean level drops the count back to zero
                        if (differs) begin
                            if (cnt_reg == CNT_LAST) begin
                                db_next   = s2_reg[gi];
                                rise_next = s2_reg[gi];
                                fall_next = ~s2_reg[gi];
                                tog_next  = tog_reg ^ s2_reg[gi];
                            end else begin
                                cnt_next = cnt_reg + CW'(1);
                            end
                        end
                    end
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg  <= '0;
                    db_reg   <= 1'b0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                    tog_reg  <= 1'b0;
                end else begin
                    cnt_reg  <= cnt_next;
                    db_reg   <= db_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                    tog_reg  <= tog_next;
                end
            end

            assign sw_db[gi]     = db_reg;
            assign sw_rise[gi]   = rise_reg;
            assign sw_fall[gi]   = fall_reg;
            assign sw_toggle[gi] = tog_reg;
        end
    endgenerate

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with N=8, M=4: reset, clean edges, bounce rejection,
// repeated press/release, simultaneous channels and reset during a pending count.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] sw;
    logic [7:0] sw_db;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic [7:0] sw_toggle;

    int checks;
    int errors;

    sw_debounce #(.N(8), .M(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .sw_db     (sw_db),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_toggle (sw_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing on a falling edge for sampling and driving
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw  = 8'hFF;
        step(3);
        checks++; if (sw_db !== 8'h00) begin errors++; $display("FAIL reset_db got %h want 00", sw_db); end
        checks++; if (sw_rise !== 8'h00) begin errors++; $display("FAIL reset_rise got %h want 00", sw_rise); end
        checks++; if (sw_fall !== 8'h00) begin errors++; $display("FAIL reset_fall got %h want 00", sw_fall); end
        checks++; if (sw_toggle !== 8'h00) begin errors++; $display("FAIL reset_toggle got %h want 00", sw_toggle); end
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            step(1);
            checks++;
            if (sw_db !== ((t >= 6) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL release_db edge %0d got %h want %h", t, sw_db, (t >= 6) ? 8'hFF : 8'h00);
            end
            checks++;
            if (sw_rise !== ((t == 6) ? 8'hFF : 8'h00)) begin
                errors++; $display("FAIL release_rise edge %0d got %h want %h", t, sw_rise, (t == 6) ? 8'hFF : 8'h00);
            end
        end
        checks++; if (sw_toggle !== 8'hFF) begin errors++; $display("FAIL release_toggle got %h want ff", sw_toggle); end
        $display("test_reset: db=%h toggle=%h", sw_db, sw_toggle);
        // Return to an all-zero baseline for the following tests
        rst = 1'b1;
        sw  = 8'h00;
        step(2);
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_clean_rise();
        sw = 8'h01;
        for (int t = 1; t <= 7; t++) begin
            step(1);
            checks++;
            if (sw_db !== ((t >= 6) ? 8'h01 : 8'h00)) begin
                errors++; $display("FAIL clean_db edge %0d got %h want %h", t, sw_db, (t >= 6) ? 8'h01 : 8'h00);
            end
            checks++;
            if (sw_rise !== ((t == 6) ? 8'h01 : 8'h00)) begin
                errors++; $display("FAIL clean_rise edge %0d got %h want %h", t, sw_rise, (t == 6) ? 8'h01 : 8'h00);
            end
            checks++;
            if (sw_fall !== 8'h00) begin
                errors++; $display("FAIL clean_fall edge %0d got %h want 00", t, sw_fall);
            end
        end
        checks++; if (sw_toggle !== 8'h01) begin errors++; $display("FAIL clean_toggle got %h want 01", sw_toggle); end
        $display("test_clean_rise: db=%h toggle=%h", sw_db, sw_toggle);
    endtask

    task automatic test_bounce();
        int rises;
        rises = 0;
        for (int c = 0; c < 12; c++) begin
            sw[2] = ((c / 3) % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
            checks++;
            if (sw_db !== 8'h01 || sw_rise !== 8'h00) begin
                errors++; $display("FAIL bounce_hold cycle %0d got db=%h rise=%h want db=01 rise=00", c, sw_db, sw_rise);
            end
        end
        sw[2] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            step(1);
            if (sw_rise[2]) rises++;
            checks++;
            if (sw_db !== ((t >= 6) ? 8'h05 : 8'h01)) begin
                errors++; $display("FAIL bounce_db edge %0d got %h want %h", t, sw_db, (t >= 6) ? 8'h05 : 8'h01);
            end
        end
        checks++; if (rises != 1) begin errors++; $display("FAIL bounce_rise_count got %0d want 1", rises); end
        checks++; if (sw_toggle !== 8'h05) begin errors++; $display("FAIL bounce_toggle got %h want 05", sw_toggle); end
        $display("test_bounce: db=%h rises=%0d", sw_db, rises);
    endtask

    task automatic test_press_release();
        int rises;
        int falls;
        logic db3, r3, f3, t3;
        rises = 0;
        falls = 0;
        // Level changes driven at cycles 0,10,..,50 show up on the outputs 5 cycles later
        for (int c = 0; c < 62; c++) begin
            sw[3] = (c < 60 && ((c / 10) % 2 == 0)) ? 1'b1 : 1'b0;
            step(1);
            db3 = (c >= 5 && c < 15) || (c >= 25 && c < 35) || (c >= 45 && c < 55);
            r3  = (c == 5) || (c == 25) || (c == 45);
            f3  = (c == 15) || (c == 35) || (c == 55);
            t3  = (c >= 5 && c < 25) || (c >= 45);
            if (sw_rise[3]) rises++;
            if (sw_fall[3]) falls++;
            checks++;
            if (sw_db !== (8'h05 | {4'b0, db3, 3'b0})) begin
                errors++; $display("FAIL press_db cycle %0d got %h want %h", c, sw_db, 8'h05 | {4'b0, db3, 3'b0});
            end
            checks++;
            if (sw_rise !== {4'b0, r3, 3'b0} || sw_fall !== {4'b0, f3, 3'b0}) begin
                errors++; $display("FAIL press_pulse cycle %0d got rise=%h fall=%h want rise=%h fall=%h",
                                   c, sw_rise, sw_fall, {4'b0, r3, 3'b0}, {4'b0, f3, 3'b0});
            end
            checks++;
            if (sw_toggle !== (8'h05 | {4'b0, t3, 3'b0})) begin
                errors++; $display("FAIL press_toggle cycle %0d got %h want %h", c, sw_toggle, 8'h05 | {4'b0, t3, 3'b0});
            end
        end
        checks++; if (rises != 3) begin errors++; $display("FAIL press_rise_count got %0d want 3", rises); end
        checks++; if (falls != 3) begin errors++; $display("FAIL press_fall_count got %0d want 3", falls); end
        $display("test_press_release: rises=%0d falls=%0d toggle=%h", rises, falls, sw_toggle);
    endtask

    task automatic test_simultaneous();
        sw[5] = 1'b1;
        step(8);
        checks++; if (sw_db !== 8'h25) begin errors++; $display("FAIL simul_setup_db got %h want 25", sw_db); end
        sw[4] = 1'b1;
        sw[5] = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            step(1);
            checks++;
            if (sw_db !== ((t >= 6) ? 8'h15 : 8'h25)) begin
                errors++; $display("FAIL simul_db edge %0d got %h want %h", t, sw_db, (t >= 6) ? 8'h15 : 8'h25);
            end
            checks++;
            if (sw_rise !== ((t == 6) ? 8'h10 : 8'h00) || sw_fall !== ((t == 6) ? 8'h20 : 8'h00)) begin
                errors++; $display("FAIL simul_pulse edge %0d got rise=%h fall=%h want rise=%h fall=%h", t, sw_rise, sw_fall,
                                   (t == 6) ? 8'h10 : 8'h00, (t == 6) ? 8'h20 : 8'h00);
            end
        end
        checks++; if (sw_toggle !== 8'h3D) begin errors++; $display("FAIL simul_toggle got %h want 3d", sw_toggle); end
        $display("test_simultaneous: db=%h toggle=%h", sw_db, sw_toggle);
    endtask

    task automatic test_reset_mid_wait();
        sw[6] = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        checks++;
        if (sw_db !== 8'h00 || sw_toggle !== 8'h00) begin
            errors++; $display("FAIL midwait_async got db=%h toggle=%h want 00 00", sw_db, sw_toggle);
        end
        for (int t = 0; t < 3; t++) begin
            step(1);
            checks++;
            if (sw_db !== 8'h00) begin errors++; $display("FAIL midwait_hold cycle %0d got %h want 00", t, sw_db); end
        end
        rst = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            step(1);
            checks++;
            if (sw_db !== ((t >= 6) ? 8'h55 : 8'h00)) begin
                errors++; $display("FAIL midwait_db edge %0d got %h want %h", t, sw_db, (t >= 6) ? 8'h55 : 8'h00);
            end
            checks++;
            if (sw_rise !== ((t == 6) ? 8'h55 : 8'h00)) begin
                errors++; $display("FAIL midwait_rise edge %0d got %h want %h", t, sw_rise, (t == 6) ? 8'h55 : 8'h00);
            end
        end
        checks++; if (sw_toggle !== 8'h55) begin errors++; $display("FAIL midwait_toggle got %h want 55", sw_toggle); end
        $display("test_reset_mid_wait: db=%h toggle=%h", sw_db, sw_toggle);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        sw  = 8'h00;
        test_reset();
        test_clean_rise();
        test_bounce();
        test_press_release();
        test_simultaneous();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
